// File: rtl/opsum_pass_sequencer.sv
// Walks the (channel_base, row_base) tile origin over the whole ofmap and issues one opsum controller start per pass.
// Latency: start -> first ctrl_start in 2 cycles; ctrl_done -> next ctrl_start in 2 cycles; last ctrl_done -> done in 2 cycles.
// Backpressure: each pass holds in WAIT until ctrl_done; start is ignored while busy, ctrl_done is ignored outside WAIT.
module opsum_pass_sequencer #(
    parameter int E_WIDTH    = 6,
    parameter int m_WIDTH    = 10,
    parameter int e_WIDTH    = 8,
    parameter int p_WIDTH    = 5,
    parameter int t_WIDTH    = 3,
    parameter int PASS_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [E_WIDTH-1:0]    E,
    input  logic [m_WIDTH-1:0]    M,
    input  logic [e_WIDTH-1:0]    e,
    input  logic [p_WIDTH-1:0]    p,
    input  logic [t_WIDTH-1:0]    t,
    output logic                  ctrl_start,
    input  logic                  ctrl_done,
    output logic [m_WIDTH-1:0]    channel_base,
    output logic [E_WIDTH-1:0]    row_base,
    output logic [PASS_WIDTH-1:0] pass_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    // Sums carry one spare bit so the end-of-range compare never sees a wrapped value.
    localparam int PT_W = p_WIDTH + t_WIDTH;
    localparam int CH_W = ((m_WIDTH > PT_W) ? m_WIDTH : PT_W) + 1;
    localparam int RW_W = ((E_WIDTH > e_WIDTH) ? E_WIDTH : e_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT    = 3'd3,
        ADVANCE = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [E_WIDTH-1:0] e_total;
    logic [m_WIDTH-1:0] m_total;
    logic [e_WIDTH-1:0] e_step;
    logic [p_WIDTH-1:0] p_lat;
    logic [t_WIDTH-1:0] t_lat;

    logic [PT_W-1:0] pt_prod;
    logic [CH_W-1:0] ch_step;
    logic [RW_W-1:0] next_row;
    logic [CH_W-1:0] next_ch;
    logic            cfg_bad;
    logic            row_fits;
    logic            ch_fits;

    // Step sizes and next tile origins derived from the latched layer config.
    always_comb begin
        pt_prod  = PT_W'(p_lat) * PT_W'(t_lat);
        ch_step  = CH_W'(pt_prod);
        next_row = RW_W'(row_base) + RW_W'(e_step);
        next_ch  = CH_W'(channel_base) + ch_step;
        row_fits = (next_row < RW_W'(e_total));
        ch_fits  = (next_ch < CH_W'(m_total));
        cfg_bad  = (e_total == '0) || (m_total == '0) || (e_step == '0) || (ch_step == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; rows are the inner loop, channels the outer loop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   state_nxt = cfg_bad ? FINISH : LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (ctrl_done) state_nxt = ADVANCE;
            ADVANCE: state_nxt = (!row_fits && !ch_fits) ? FINISH : LAUNCH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Config latch, tile origin walk, pass counter and sticky config error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_total      <= '0;
            m_total      <= '0;
            e_step       <= '0;
            p_lat        <= '0;
            t_lat        <= '0;
            channel_base <= '0;
            row_base     <= '0;
            pass_idx     <= '0;
            cfg_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        e_total      <= E;
                        m_total      <= M;
                        e_step       <= e;
                        p_lat        <= p;
                        t_lat        <= t;
                        channel_base <= '0;
                        row_base     <= '0;
                        pass_idx     <= '0;
                        cfg_err      <= 1'b0;
                    end
                end
                CHECK: begin
                    if (cfg_bad) cfg_err <= 1'b1;
                end
                ADVANCE: begin
                    // On the final pass both origins keep their last values.
                    if (row_fits || ch_fits) begin
                        if (row_fits) begin
                            row_base <= next_row[E_WIDTH-1:0];
                        end else begin
                            row_base     <= '0;
                            channel_base <= next_ch[m_WIDTH-1:0];
                        end
                        if (pass_idx != '1) pass_idx <= pass_idx + PASS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded purely from the registered state.
    assign ctrl_start = (state == LAUNCH);
    assign done       = (state == FINISH);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_opsum_pass_sequencer.sv
// Self-checking bench: a scoreboard of expected (channel_base, row_base, pass_idx) per ctrl_start,
// an opsum-controller responder with programmable done delay, and scenario tasks for
// config errors, stray done pulses, ignored starts and reset in the middle of a pass.
module tb_opsum_pass_sequencer;

    localparam int E_WIDTH    = 6;
    localparam int m_WIDTH    = 10;
    localparam int e_WIDTH    = 8;
    localparam int p_WIDTH    = 5;
    localparam int t_WIDTH    = 3;
    localparam int PASS_WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [E_WIDTH-1:0]    cfg_E;
    logic [m_WIDTH-1:0]    cfg_M;
    logic [e_WIDTH-1:0]    cfg_e;
    logic [p_WIDTH-1:0]    cfg_p;
    logic [t_WIDTH-1:0]    cfg_t;
    logic                  ctrl_start;
    logic                  ctrl_done;
    logic [m_WIDTH-1:0]    channel_base;
    logic [E_WIDTH-1:0]    row_base;
    logic [PASS_WIDTH-1:0] pass_idx;
    logic                  busy;
    logic                  done;
    logic                  cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int ch;
        int row;
        int idx;
    } pass_t;

    pass_t exp_q[$];

    opsum_pass_sequencer #(
        .E_WIDTH(E_WIDTH), .m_WIDTH(m_WIDTH), .e_WIDTH(e_WIDTH),
        .p_WIDTH(p_WIDTH), .t_WIDTH(t_WIDTH), .PASS_WIDTH(PASS_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .E(cfg_E), .M(cfg_M), .e(cfg_e), .p(cfg_p), .t(cfg_t),
        .ctrl_start(ctrl_start), .ctrl_done(ctrl_done),
        .channel_base(channel_base), .row_base(row_base), .pass_idx(pass_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one layer: builds the expected pass list, pulses start, answers each ctrl_start
    // with ctrl_done after dly cycles and compares every pass against the scoreboard.
    task automatic run_layer(input int ev_E, input int ev_M, input int ev_e, input int ev_p,
                             input int ev_t, input int dly, input bit stray_launch,
                             input int start_in_wait, input bit start_at_done,
                             input int reset_at, input string tag);
        bit bad;
        int step;
        int idx;
        int budget;
        int nstarts;
        int cnt;
        int done_cyc;
        int last_done_cyc;
        bit waiting;
        bit got_done;
        bit aborted;
        pass_t ep;
        logic [m_WIDTH-1:0]    cur_ch;
        logic [E_WIDTH-1:0]    cur_row;
        int cur_idx;

        step = ev_p * ev_t;
        bad = (ev_E == 0) || (ev_M == 0) || (ev_e == 0) || (step == 0);
        exp_q.delete();
        idx = 0;
        if (!bad) begin
            for (int ch = 0; ch < ev_M; ch += step) begin
                for (int r = 0; r < ev_E; r += ev_e) begin
                    exp_q.push_back('{ch, r, idx});
                    idx++;
                end
            end
        end
        budget = 200 + idx * (dly + 8);
        nstarts = 0; cnt = 0; waiting = 0; got_done = 0; aborted = 0;
        done_cyc = -1; last_done_cyc = -100; cur_ch = '0; cur_row = '0; cur_idx = -1;

        @(negedge clk);
        cfg_E = E_WIDTH'(ev_E); cfg_M = m_WIDTH'(ev_M); cfg_e = e_WIDTH'(ev_e);
        cfg_p = p_WIDTH'(ev_p); cfg_t = t_WIDTH'(ev_t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_E = E_WIDTH'($urandom); cfg_M = m_WIDTH'($urandom); cfg_e = e_WIDTH'($urandom);
        cfg_p = p_WIDTH'($urandom); cfg_t = t_WIDTH'($urandom);
        checks++;
        if (cfg_err !== 1'b0 || busy !== 1'b1 || pass_idx !== '0) begin
            errors++;
            $display("FAIL %s check_state: cfg_err=%b busy=%b pass_idx=%0d, want 0 1 0", tag, cfg_err, busy, pass_idx);
        end

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            ctrl_done = 1'b0;
            start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (ctrl_start) begin
                if (nstarts == 0) begin
                    checks++;
                    if (cyc != 0) begin
                        errors++;
                        $display("FAIL %s first_launch: at cycle %0d after check, want 0", tag, cyc);
                    end
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_ctrl_start: got (%0d,%0d) idx %0d, want no pass", tag, channel_base, row_base, pass_idx);
                end else begin
                    ep = exp_q.pop_front();
                    if (channel_base !== m_WIDTH'(ep.ch) || row_base !== E_WIDTH'(ep.row) || pass_idx !== PASS_WIDTH'(ep.idx)) begin
                        errors++;
                        $display("FAIL %s pass: got (%0d,%0d) idx %0d, want (%0d,%0d) idx %0d",
                                 tag, channel_base, row_base, pass_idx, ep.ch, ep.row, ep.idx);
                    end
                end
                cur_ch = channel_base; cur_row = row_base; cur_idx = nstarts;
                nstarts++;
                cnt = dly;
                waiting = 1'b1;
                if (stray_launch && nstarts == 1) ctrl_done = 1'b1;
            end else if (waiting) begin
                checks++;
                if (channel_base !== cur_ch || row_base !== cur_row || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s wait_stable: got (%0d,%0d) busy=%b, want (%0d,%0d) busy=1", tag, channel_base, row_base, busy, cur_ch, cur_row);
                end
                if (reset_at == cur_idx) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    checks++;
                    if (ctrl_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 ||
                        channel_base !== '0 || row_base !== '0 || pass_idx !== '0) begin
                        errors++;
                        $display("FAIL %s async_reset: cs=%b d=%b busy=%b err=%b ch=%0d row=%0d idx=%0d, want all 0",
                                 tag, ctrl_start, done, busy, cfg_err, channel_base, row_base, pass_idx);
                    end
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        checks++;
                        if (done !== 1'b0 || busy !== 1'b0) begin
                            errors++;
                            $display("FAIL %s reset_hold: done=%b busy=%b, want 0 0", tag, done, busy);
                        end
                    end
                    reset = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                if (start_in_wait == cur_idx && cnt == dly) start = 1'b1;
                if (cnt == 0) begin
                    ctrl_done = 1'b1;
                    waiting = 1'b0;
                    last_done_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
        end

        if (aborted) begin
            exp_q.delete();
        end else begin
            checks++;
            if (!got_done) begin
                errors++;
                $display("FAIL %s done_timeout: no done within %0d cycles, want done", tag, budget);
            end else begin
                checks++;
                if (bad ? (done_cyc != 0) : (done_cyc != last_done_cyc + 2)) begin
                    errors++;
                    $display("FAIL %s done_latency: done at cycle %0d, want %0d", tag, done_cyc, bad ? 0 : last_done_cyc + 2);
                end
                if (!bad) begin
                    checks++;
                    if (channel_base !== cur_ch || row_base !== cur_row) begin
                        errors++;
                        $display("FAIL %s final_bases: got (%0d,%0d), want (%0d,%0d)", tag, channel_base, row_base, cur_ch, cur_row);
                    end
                end
                checks++;
                if (cfg_err !== bad) begin
                    errors++;
                    $display("FAIL %s cfg_err: got %b, want %b", tag, cfg_err, bad);
                end
                checks++;
                if (exp_q.size() != 0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s completion: %0d passes missing busy=%b, want 0 missing busy=1", tag, exp_q.size(), busy);
                end
                if (start_at_done) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || ctrl_start !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_after_done: busy=%b done=%b cs=%b, want 0 0 0", tag, busy, done, ctrl_start);
                end
                if (start_at_done) begin
                    repeat (3) @(negedge clk);
                    checks++;
                    if (busy !== 1'b0 || ctrl_start !== 1'b0) begin
                        errors++;
                        $display("FAIL %s start_at_done_ignored: busy=%b cs=%b, want 0 0", tag, busy, ctrl_start);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; ctrl_done = 1'b0;
        cfg_E = '0; cfg_M = '0; cfg_e = '0; cfg_p = '0; cfg_t = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (ctrl_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cfg_err !== 1'b0 ||
            channel_base !== '0 || row_base !== '0 || pass_idx !== '0) begin
            errors++;
            $display("FAIL reset_state: cs=%b d=%b busy=%b err=%b ch=%0d row=%0d idx=%0d, want all 0",
                     ctrl_start, done, busy, cfg_err, channel_base, row_base, pass_idx);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ctrl_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b cs=%b, want 0 0", busy, ctrl_start);
        end
    endtask

    task automatic test_multi_pass();
        run_layer(13, 16, 4, 4, 2, 0, 1'b0, -1, 1'b0, -1, "multi_pass");
    endtask

    task automatic test_single_pass();
        run_layer(8, 5, 8, 5, 1, 3, 1'b0, -1, 1'b0, -1, "single_pass");
    endtask

    task automatic test_cfg_err();
        run_layer(13, 16, 0, 4, 2, 0, 1'b0, -1, 1'b0, -1, "cfg_e_zero");
        repeat (3) @(negedge clk);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_sticky: got %b, want 1", cfg_err);
        end
        run_layer(8, 8, 2, 3, 0, 0, 1'b0, -1, 1'b0, -1, "cfg_t_zero");
        run_layer(4, 4, 2, 2, 1, 1, 1'b0, -1, 1'b0, -1, "cfg_err_clear");
    endtask

    task automatic test_slow_done_stray();
        @(negedge clk);
        ctrl_done = 1'b1;
        @(negedge clk);
        ctrl_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || ctrl_start !== 1'b0) begin
            errors++;
            $display("FAIL stray_done_idle: busy=%b cs=%b, want 0 0", busy, ctrl_start);
        end
        run_layer(4, 2, 2, 1, 1, 100, 1'b1, -1, 1'b0, -1, "slow_done");
    endtask

    task automatic test_start_ignored();
        run_layer(13, 16, 4, 4, 2, 1, 1'b0, 2, 1'b1, -1, "start_ignored");
    endtask

    task automatic test_reset_mid_wait();
        run_layer(13, 16, 4, 4, 2, 2, 1'b0, -1, 1'b0, 3, "reset_mid_wait");
        run_layer(13, 16, 4, 4, 2, 0, 1'b0, -1, 1'b0, -1, "rerun_after_reset");
    endtask

    initial begin
        test_reset();
        test_multi_pass();
        test_single_pass();
        test_cfg_err();
        test_slow_done_stray();
        test_start_ignored();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
